// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin front end for a single-port synchronous RAM.
// The IF port (read-only) and the MEM port (read/write) share the RAM. Reads
// return after one cycle and are steered back to the port that issued them.
module ram_port_arbiter #(
    parameter int REG_WIDTH = 64,
    parameter int REG_DEPTH = 64,
    localparam int AW = $clog2(REG_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    // instruction-fetch port
    input  logic                 if_req,
    input  logic [AW-1:0]        if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [REG_WIDTH-1:0] if_rdata,
    // memory-stage port
    input  logic                 mem_req,
    input  logic                 mem_we,
    input  logic [AW-1:0]        mem_addr,
    input  logic [REG_WIDTH-1:0] mem_wdata,
    output logic                 mem_gnt,
    output logic                 mem_rvalid,
    output logic [REG_WIDTH-1:0] mem_rdata,
    // RAM side
    output logic                 ram_cs_n,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic [REG_WIDTH-1:0] ram_din,
    input  logic [REG_WIDTH-1:0] ram_dout
);

    typedef enum logic {
        PORT_IF  = 1'b0,
        PORT_MEM = 1'b1
    } port_e;

    port_e last_gnt;
    port_e rd_owner;
    logic  rd_pend;
    logic  rd_gnt;

    // Grant selection: single requester wins outright, conflicts go to the
    // port that was not granted last time. Nothing is granted during reset.
    always_comb begin
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (!rst) begin
            if (if_req && mem_req) begin
                if (last_gnt == PORT_IF) begin
                    mem_gnt = 1'b1;
                end else begin
                    if_gnt = 1'b1;
                end
            end else begin
                if_gnt  = if_req;
                mem_gnt = mem_req;
            end
        end
        rd_gnt = if_gnt | (mem_gnt & ~mem_we);
    end

    // RAM drive from the winning port; all-quiet when nobody is granted.
    always_comb begin
        ram_cs_n = 1'b1;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (if_gnt) begin
            ram_cs_n = 1'b0;
            ram_addr = if_addr;
        end else if (mem_gnt) begin
            ram_cs_n = 1'b0;
            ram_we   = mem_we;
            ram_addr = mem_addr;
            ram_din  = mem_wdata;
        end
    end

    // Arbitration history and one-deep read tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= PORT_IF;
            rd_pend  <= 1'b0;
            rd_owner <= PORT_IF;
        end else begin
            if (if_gnt) begin
                last_gnt <= PORT_IF;
            end else if (mem_gnt) begin
                last_gnt <= PORT_MEM;
            end
            rd_pend <= rd_gnt;
            if (rd_gnt) begin
                rd_owner <= if_gnt ? PORT_IF : PORT_MEM;
            end
        end
    end

    // Response steering; gating with rst drops a read granted just before reset.
    always_comb begin
        if_rvalid  = rd_pend && (rd_owner == PORT_IF) && !rst;
        mem_rvalid = rd_pend && (rd_owner == PORT_MEM) && !rst;
        if_rdata   = if_rvalid ? ram_dout : '0;
        mem_rdata  = mem_rvalid ? ram_dout : '0;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester front end that sits directly upstream of the CPU's single-port synchronous RAM.
- Arbitrates between the instruction-fetch port (IF, read-only) and the memory-stage port (MEM, read/write).
- Drives the RAM's chip-select, write-enable, address and write-data each cycle.
- Steers the RAM's one-cycle-latency read data back to whichever port issued the read.

Parameters:
- REG_WIDTH, 64, data word width in bits.
- REG_DEPTH, 64, number of RAM words; AW = $clog2(REG_DEPTH) is the address width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request.
- if_addr  in  AW  IF word address.
- if_gnt  out  1  IF request accepted this cycle (combinational).
- if_rvalid  out  1  IF read data valid.
- if_rdata  out  REG_WIDTH  IF read data.
- mem_req  in  1  MEM request.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  AW  MEM word address.
- mem_wdata  in  REG_WIDTH  MEM write data.
- mem_gnt  out  1  MEM request accepted this cycle (combinational).
- mem_rvalid  out  1  MEM read data valid.
- mem_rdata  out  REG_WIDTH  MEM read data.
- ram_cs_n  out  1  RAM chip select, active-low.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_din  out  REG_WIDTH  RAM write data.
- ram_dout  in  REG_WIDTH  RAM read data; valid the cycle after a read access (cs_n=0, we=0).

Behaviour:
- Grant is combinational; at most one of if_gnt/mem_gnt is high per cycle. A grant is issued only for a requesting port.
- Single requester: that port is granted the same cycle.
- Both requesting: round-robin arbitration. The port not granted last time wins.
- State `last_gnt` (0 = IF, 1 = MEM) updates on every cycle with a grant.
- `last_gnt` resets to 0, so MEM wins the first conflict after reset.
- RAM drive when granted: ram_cs_n=0 and ram_addr = winner's address.
  - IF winner: ram_we=0.
  - MEM winner: ram_we=mem_we, ram_din=mem_wdata.
- RAM drive when idle: ram_cs_n=1, ram_we=0, ram_addr=0, ram_din=0.
- Read tracking uses flops `rd_pend` and `rd_owner`.
  - Both are set on posedge when a read is granted; `rd_pend` clears on any cycle with no read granted.
  - x_rvalid = rd_pend & (rd_owner==x).
  - x_rdata = ram_dout when x_rvalid, else 0.
- Read latency is exactly 1 cycle, grant to rvalid.
- Fully pipelined: back-to-back reads, from the same or alternating ports, are granted every cycle. Each returns rvalid exactly one cycle later.
- MEM writes never produce mem_rvalid. A write granted in cycle N takes effect in the RAM at edge N.
- A read of the same address in cycle N+1 returns the new data.
- No backpressure on responses: rvalid is a one-cycle pulse and the requester must capture it.
- Requests are level-sensitive. A port held off keeps its req, addr and data stable until granted. The arbiter never drops or reorders requests.
- Reset: while rst=1, all gnt and rvalid are 0, ram_cs_n=1, rd_pend=0 and last_gnt=0.
- A read granted in the cycle before reset asserts yields no rvalid.
- Requests presented during reset are ignored and not granted.
- Address width arithmetic: addresses pass through unmodified. No range check; REG_DEPTH is a power of two.

Test Plan:
- Reset, then MEM write addr 5 data 0xDEAD_BEEF, then IF read addr 5 → if_gnt the same cycle; if_rvalid=1 and if_rdata=0xDEADBEEF one cycle later; mem_rvalid stays 0.
- Both ports request continuously for 6 cycles after reset (IF addr 1, MEM read addr 2) → grants alternate MEM, IF, MEM, IF, MEM, IF; rvalid alternates accordingly one cycle later with data from addrs 2/1.
- IF streams reads addr 0..7 with no MEM traffic → if_gnt every cycle; 8 consecutive if_rvalid pulses with data in address order.
- MEM write addr 9 = 0x1234 in cycle N while IF reads addr 9 → round-robin resolves the order. If IF goes first it returns the old value; otherwise it returns 0x1234. No rvalid on mem.
- Assert rst in the cycle after IF is granted a read of addr 3 → no if_rvalid during or after reset; ram_cs_n=1 throughout reset.
- Idle (no requests) for 4 cycles → ram_cs_n=1, all gnt and rvalid 0, both rdata 0.
